output_delta_cost_unit: RTL and testbench
=========================================

Name: output_delta_cost_unit

Overview:
Streams the output-layer activations of one training vector, one neuron per accepted sample. For each neuron it produces the backprop error term delta = f'(a) * (a - t). It also accumulates the squared-error cost over the whole vector. It generalises the single-neuron delta/cost stage to NOUT neurons, with these additions: selectable activation derivative, Q-format fixed-point scaling, saturation, per-neuron index tagging, a vector-complete strobe and a synchronous clear. It sits between the forward-pass output layer and the hidden-layer delta/weight-update logic.

Parameters:
DWIDTH, 32, data width, signed two's complement, Q(DWIDTH-FRAC).FRAC.
FRAC, 16, number of fractional bits; ONE = 1<<FRAC.
NOUT, 10, output neurons per vector (>=2).
IDXW, 4, index width; 2^IDXW >= NOUT.
ACT_MODE, 0, derivative selection: 0 sigmoid a*(ONE-a); 1 linear ONE; 2 tanh ONE-a*a.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of vector progress
in_valid  in  1  a3/t valid; always accepted (no backpressure)
a3  in  DWIDTH  signed activation of current neuron
t  in  DWIDTH  signed target of current neuron
delta_valid  out  1  delta/delta_idx valid this cycle
delta  out  DWIDTH  signed delta of neuron delta_idx
delta_idx  out  IDXW  neuron index of delta (0..NOUT-1)
cost_valid  out  1  one-cycle pulse: cost updated for completed vector
cost  out  DWIDTH  signed sum of (a-t)^2 over last completed vector; held until next completion
busy  out  1  high while a vector is partially collected or pipeline non-empty
sat_flag  out  1  sticky: any saturation since reset/clr

Behaviour:
- Reset (rst_n=0, async): all outputs 0; in_idx=0, accumulator=0, pipeline valids=0, FSM=IDLE.
- mulq(x,y): full 2*DWIDTH signed product, arithmetic shift right FRAC (floor), saturate to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
- Subtraction err=a3-t: computed at DWIDTH+1 bits, saturated to DWIDTH.
- Any saturation in err, da, delta, sq or the accumulator sets sat_flag.
- Stage 1, the cycle after acceptance, registers:
  - err;
  - da, by ACT_MODE: mode 0 mulq(a3, ONE-a3); mode 1 ONE; mode 2 ONE-mulq(a3,a3), saturated;
  - idx = in_idx;
  - v1 = in_valid.
- Stage 2 registers:
  - delta = mulq(da,err);
  - sq = mulq(err,err);
  - delta_idx = idx;
  - delta_valid = v1.
- Latency: in_valid at cycle N -> delta_valid at N+2. Throughput: 1 sample/cycle. Back-to-back samples are allowed.
- in_idx: increments on each accepted sample and wraps from NOUT-1 to 0.
- Accumulator, updated at stage 2 when v1:
  - idx != NOUT-1: acc <= sat(acc + sq).
  - idx == NOUT-1: cost <= sat(acc + sq), cost_valid=1 that cycle, acc <= 0.
  - cost_valid therefore coincides with the delta_valid of the last neuron.
- FSM:
  - IDLE -> COLLECT on accepted sample.
  - COLLECT -> IDLE when the last-index sample leaves stage 2 with no new sample in flight. Otherwise it stays in COLLECT; a new vector may start in the cycle directly after the last index.
  - busy = (state==COLLECT) | v1 | delta_valid.
- clr (synchronous), effective next edge:
  - in_idx=0, acc=0, v1=0, delta_valid=0: in-flight samples are dropped, no cost_valid.
  - sat_flag=0, FSM=IDLE.
  - cost keeps its last value.
- clr together with in_valid: clr wins and the sample is discarded.
- clr is accepted mid-vector; the following sample is treated as index 0.
- rst_n deasserted mid-vector: same as reset, including cost=0.

Test Plan:
1. ACT_MODE=0, a3=0x0000C000 (0.75), t=0x00010000 (1.0), single sample -> 2 cycles later delta_valid=1, delta_idx=0, delta=0xFFFFF400 (-0.046875).
2. ACT_MODE=0, 10 back-to-back samples as in test 1 -> delta_idx 0..9 on consecutive cycles. On idx 9: cost_valid=1, cost=0x0000A000 (0.625). busy falls the next cycle.
3. ACT_MODE=2, a3=0x00008000, t=0 -> delta=0x00006000 (0.375). ACT_MODE=1, same inputs -> delta=0x00008000.
4. a3=0x7FFFFFFF, t=0x80000000 -> err, delta and sq saturate to 0x7FFFFFFF; sat_flag=1 and stays set until clr.
5. Feed 5 samples, then assert clr together with a 6th -> no cost_valid. The next 10 samples produce delta_idx starting at 0 and cost equal to those 10 only. Before completion, cost holds its previous value.
6. Assert rst_n=0 asynchronously mid-vector, between clock edges -> all outputs 0 immediately; first sample after release gets delta_idx=0.

Source files
------------

// File: rtl/output_delta_cost_unit.sv
// rtl/output_delta_cost_unit.sv - output-layer delta and squared-error cost pipeline
// Two-stage Q-format pipeline: stage 1 forms err and f'(a), stage 2 forms delta, sq and the cost sum.
module output_delta_cost_unit #(
   parameter int DWIDTH   = 32,
   parameter int FRAC     = 16,
   parameter int NOUT     = 10,
   parameter int IDXW     = 4,
   parameter int ACT_MODE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] a3,
   input  logic [DWIDTH-1:0] t,
   output logic              delta_valid,
   output logic [DWIDTH-1:0] delta,
   output logic [IDXW-1:0]   delta_idx,
   output logic              cost_valid,
   output logic [DWIDTH-1:0] cost,
   output logic              busy,
   output logic              sat_flag
);
   localparam logic [DWIDTH-1:0] ONE  = DWIDTH'(1) << FRAC;
   localparam logic [DWIDTH-1:0] MAXV = {1'b0, {(DWIDTH-1){1'b1}}};
   localparam logic [DWIDTH-1:0] MINV = {1'b1, {(DWIDTH-1){1'b0}}};
   localparam logic [IDXW-1:0]   LAST = IDXW'(NOUT-1);

   typedef struct packed {
      logic              sat;
      logic [DWIDTH-1:0] val;
   } sres_t;

   typedef enum logic {IDLE, COLLECT} state_t;

   function automatic sres_t sat_wide(input logic [DWIDTH:0] s);
      sres_t r;
      r.sat = s[DWIDTH] ^ s[DWIDTH-1];
      r.val = r.sat ? (s[DWIDTH] ? MINV : MAXV) : s[DWIDTH-1:0];
      return r;
   endfunction

   function automatic sres_t sub_sat(input logic [DWIDTH-1:0] x, input logic [DWIDTH-1:0] y);
      return sat_wide({x[DWIDTH-1], x} - {y[DWIDTH-1], y});
   endfunction

   function automatic sres_t add_sat(input logic [DWIDTH-1:0] x, input logic [DWIDTH-1:0] y);
      return sat_wide({x[DWIDTH-1], x} + {y[DWIDTH-1], y});
   endfunction

   // Floor-shifted Q product; fits only when the bits above the result sign all agree.
   function automatic sres_t mulq(input logic [DWIDTH-1:0] x, input logic [DWIDTH-1:0] y);
      logic signed [2*DWIDTH-1:0] p;
      logic        [DWIDTH:0]     top;
      sres_t r;
      p     = $signed({{DWIDTH{x[DWIDTH-1]}}, x}) * $signed({{DWIDTH{y[DWIDTH-1]}}, y});
      p     = p >>> FRAC;
      top   = p[2*DWIDTH-1:DWIDTH-1];
      r.sat = !((&top) || !(|top));
      r.val = r.sat ? (p[2*DWIDTH-1] ? MINV : MAXV) : p[DWIDTH-1:0];
      return r;
   endfunction

   state_t            state, state_nx;
   logic [IDXW-1:0]   in_idx, idx_q;
   logic [DWIDTH-1:0] err_q, da_q, acc;
   logic              v1;

   sres_t err_s, oma_s, mq0_s, aa_s, om2_s, dl_s, sq_s, acc_s;
   logic [DWIDTH-1:0] da_c;
   logic              da_sat;
   logic              last_out;

   assign err_s = sub_sat(a3, t);
   assign oma_s = sub_sat(ONE, a3);
   assign mq0_s = mulq(a3, oma_s.val);
   assign aa_s  = mulq(a3, a3);
   assign om2_s = sub_sat(ONE, aa_s.val);

   always_comb begin
      da_c   = ONE;
      da_sat = 1'b0;
      if (ACT_MODE == 0) begin
         da_c   = mq0_s.val;
         da_sat = oma_s.sat | mq0_s.sat;
      end else if (ACT_MODE == 2) begin
         da_c   = om2_s.val;
         da_sat = aa_s.sat | om2_s.sat;
      end
   end

   assign dl_s     = mulq(da_q, err_q);
   assign sq_s     = mulq(err_q, err_q);
   assign acc_s    = add_sat(acc, sq_s.val);
   assign last_out = v1 && (idx_q == LAST);

   always_comb begin
      state_nx = state;
      if (clr) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    if (in_valid) state_nx = COLLECT;
            COLLECT: if (last_out && !in_valid) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_idx      <= '0;
         idx_q       <= '0;
         err_q       <= '0;
         da_q        <= '0;
         v1          <= 1'b0;
         acc         <= '0;
         delta_valid <= 1'b0;
         delta       <= '0;
         delta_idx   <= '0;
         cost_valid  <= 1'b0;
         cost        <= '0;
         sat_flag    <= 1'b0;
      end else begin
         state      <= state_nx;
         cost_valid <= 1'b0;
         if (clr) begin
            in_idx      <= '0;
            acc         <= '0;
            v1          <= 1'b0;
            delta_valid <= 1'b0;
            sat_flag    <= 1'b0;
         end else begin
            v1          <= in_valid;
            delta_valid <= v1;
            if (in_valid) begin
               err_q  <= err_s.val;
               da_q   <= da_c;
               idx_q  <= in_idx;
               in_idx <= (in_idx == LAST) ? '0 : in_idx + 1'b1;
            end
            if (v1) begin
               delta     <= dl_s.val;
               delta_idx <= idx_q;
               if (idx_q == LAST) begin
                  cost       <= acc_s.val;
                  cost_valid <= 1'b1;
                  acc        <= '0;
               end else begin
                  acc <= acc_s.val;
               end
            end
            if ((in_valid && (err_s.sat || da_sat)) ||
                (v1 && (dl_s.sat || sq_s.sat || acc_s.sat)))
               sat_flag <= 1'b1;
         end
      end
   end

   assign busy = (state == COLLECT) | v1 | delta_valid;

endmodule

// File: tb/tb_output_delta_cost_unit.sv
// tb/tb_output_delta_cost_unit.sv - randomized and directed checks of output_delta_cost_unit
// Three instances (one per ACT_MODE) share stimulus; a transaction-level model predicts every output.
module tb_output_delta_cost_unit;
   localparam int     NOUT = 10;
   localparam longint ONE  = 64'sd65536;
   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   logic clk = 1'b0;
   logic rst_n, clr, in_valid;
   logic [31:0] a3, t;
   logic [2:0]       dv, cv, bz, sf;
   logic [2:0][31:0] dd, cc;
   logic [2:0][3:0]  di;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      output_delta_cost_unit #(.DWIDTH(32), .FRAC(16), .NOUT(NOUT), .IDXW(4), .ACT_MODE(g)) dut (
         .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .a3(a3), .t(t),
         .delta_valid(dv[g]), .delta(dd[g]), .delta_idx(di[g]), .cost_valid(cv[g]),
         .cost(cc[g]), .busy(bz[g]), .sat_flag(sf[g]));
   end

   // Reference model: one in-flight record per mode plus the visible output state.
   bit     fl_v[3], fl_dsat[3], e_dv[3], e_cv[3], m_sat[3], coll[3];
   longint fl_delta[3], fl_sq[3], e_delta[3], e_cost[3], acc[3];
   int     fl_idx[3], e_idx[3], m_idx[3];

   function automatic longint clampv(input longint v);
      return (v > MAXV) ? MAXV : ((v < MINV) ? MINV : v);
   endfunction

   function automatic longint mulq(input longint x, input longint y);
      return (x * y) >>> 16;
   endfunction

   task automatic model_accept(input int m, input longint a, input longint tt);
      longint e, err, r, p, da, d, s;
      bit fsat;
      e = a - tt;
      err = clampv(e);
      fsat = (e != err);
      if (m == 0) begin
         r = clampv(ONE - a);
         fsat |= (r != ONE - a);
         p = mulq(a, r);
         da = clampv(p);
         fsat |= (p != da);
      end else if (m == 1) begin
         da = ONE;
      end else begin
         p = mulq(a, a);
         r = clampv(p);
         fsat |= (p != r);
         p = ONE - r;
         da = clampv(p);
         fsat |= (p != da);
      end
      if (fsat) m_sat[m] = 1'b1;
      d = mulq(da, err);
      s = mulq(err, err);
      fl_delta[m] = clampv(d);
      fl_sq[m]    = clampv(s);
      fl_dsat[m]  = (d != fl_delta[m]) || (s != fl_sq[m]);
      fl_idx[m]   = m_idx[m];
      fl_v[m]     = 1'b1;
      m_idx[m]    = (m_idx[m] + 1) % NOUT;
      coll[m]     = 1'b1;
   endtask

   always @(posedge clk or negedge rst_n) begin : model
      longint s;
      for (int m = 0; m < 3; m++) begin
         if (!rst_n) begin
            fl_v[m] = 0; e_dv[m] = 0; e_cv[m] = 0; m_sat[m] = 0; coll[m] = 0;
            e_delta[m] = 0; e_cost[m] = 0; acc[m] = 0; e_idx[m] = 0; m_idx[m] = 0;
         end else if (clr) begin
            fl_v[m] = 0; e_dv[m] = 0; e_cv[m] = 0; m_sat[m] = 0; coll[m] = 0;
            acc[m] = 0; m_idx[m] = 0;
         end else begin
            e_cv[m] = 0;
            e_dv[m] = fl_v[m];
            if (fl_v[m]) begin
               e_delta[m] = fl_delta[m];
               e_idx[m]   = fl_idx[m];
               s = clampv(acc[m] + fl_sq[m]);
               if (s != acc[m] + fl_sq[m] || fl_dsat[m]) m_sat[m] = 1'b1;
               if (fl_idx[m] == NOUT-1) begin
                  e_cost[m] = s; e_cv[m] = 1'b1; acc[m] = 0; coll[m] = 1'b0;
               end else begin
                  acc[m] = s;
               end
            end
            fl_v[m] = 1'b0;
            if (in_valid) model_accept(m, longint'($signed(a3)), longint'($signed(t)));
         end
      end
   end

   task automatic check(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s mode%0d actual=0x%08h required=0x%08h at %0t", name, m, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         for (int m = 0; m < 3; m++) begin
            check("delta_valid", m, 32'(dv[m]), 32'(e_dv[m]));
            if (e_dv[m]) begin
               check("delta", m, dd[m], 32'(e_delta[m]));
               check("delta_idx", m, 32'(di[m]), 32'(e_idx[m]));
            end
            check("cost_valid", m, 32'(cv[m]), 32'(e_cv[m]));
            check("cost", m, cc[m], 32'(e_cost[m]));
            check("busy", m, 32'(bz[m]), 32'(coll[m] | fl_v[m] | e_dv[m]));
            check("sat_flag", m, 32'(sf[m]), 32'(m_sat[m]));
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      for (int m = 0; m < 3; m++) begin
         check({tag, "_dv"}, m, 32'(dv[m]), 32'd0);
         check({tag, "_delta"}, m, dd[m], 32'd0);
         check({tag, "_idx"}, m, 32'(di[m]), 32'd0);
         check({tag, "_cv"}, m, 32'(cv[m]), 32'd0);
         check({tag, "_cost"}, m, cc[m], 32'd0);
         check({tag, "_busy"}, m, 32'(bz[m]), 32'd0);
         check({tag, "_sat"}, m, 32'(sf[m]), 32'd0);
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b);
      a3 = a; t = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   function automatic logic [31:0] rnd_val();
      int k;
      k = $urandom_range(0, 19);
      if (k < 16) return 32'($signed($urandom_range(0, 262144)) - 131072);
      if (k == 16) return 32'h7FFFFFFF;
      if (k == 17) return 32'h80000000;
      return $urandom();
   endfunction

   initial begin
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; a3 = '0; t = '0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // single sigmoid-derivative sample
      send(32'h0000C000, 32'h00010000);
      @(negedge clk);
      check("t1_dv", 0, 32'(dv[0]), 32'd1);
      check("t1_idx", 0, 32'(di[0]), 32'd0);
      check("t1_delta", 0, dd[0], 32'hFFFFF400);
      pulse_clr();

      // full vector back to back
      for (int i = 0; i < NOUT; i++) begin
         a3 = 32'h0000C000; t = 32'h00010000; in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("t2_idx8", 0, 32'(di[0]), 32'd8);
      @(negedge clk);
      check("t2_idx9", 0, 32'(di[0]), 32'd9);
      check("t2_cv", 0, 32'(cv[0]), 32'd1);
      check("t2_cost", 0, cc[0], 32'h0000A000);
      check("t2_busy_hi", 0, 32'(bz[0]), 32'd1);
      @(negedge clk);
      check("t2_busy_lo", 0, 32'(bz[0]), 32'd0);
      check("t2_cv_lo", 0, 32'(cv[0]), 32'd0);

      // tanh and linear derivatives
      send(32'h00008000, 32'h00000000);
      @(negedge clk);
      check("t3_tanh", 2, dd[2], 32'h00006000);
      check("t3_lin", 1, dd[1], 32'h00008000);
      pulse_clr();

      // saturation and sticky flag
      send(32'h7FFFFFFF, 32'h80000000);
      check("t4_sat_set", 1, 32'(sf[1]), 32'd1);
      @(negedge clk);
      check("t4_delta", 1, dd[1], 32'h7FFFFFFF);
      repeat (5) @(negedge clk);
      check("t4_sat_hold", 1, 32'(sf[1]), 32'd1);
      pulse_clr();
      check("t4_sat_clr", 1, 32'(sf[1]), 32'd0);

      // clr mid-vector together with a sample
      for (int i = 0; i < 5; i++) begin
         a3 = rnd_val(); t = rnd_val(); in_valid = 1'b1;
         @(negedge clk);
      end
      a3 = 32'h00008000; t = '0; in_valid = 1'b1; clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      for (int j = 0; j <= NOUT; j++) begin
         in_valid = (j < NOUT);
         a3 = 32'h00008000; t = '0;
         @(negedge clk);
         if (j == 0) check("t5_dropped", 0, 32'(dv[0]), 32'd0);
         else begin
            check("t5_idx", 0, 32'(di[0]), 32'(j - 1));
            if (j < NOUT) begin
               check("t5_no_cv", 0, 32'(cv[0]), 32'd0);
               check("t5_cost_hold", 0, cc[0], 32'h0000A000);
            end
         end
      end
      in_valid = 1'b0;
      for (int m = 0; m < 3; m++) begin
         check("t5_cv", m, 32'(cv[m]), 32'd1);
         check("t5_cost", m, cc[m], 32'h00028000);
      end

      // asynchronous reset mid-vector
      for (int i = 0; i < 3; i++) begin
         a3 = 32'h0000C000; t = 32'h00010000; in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(32'h0000C000, 32'h00010000);
      @(negedge clk);
      for (int m = 0; m < 3; m++) begin
         check("t6_dv", m, 32'(dv[m]), 32'd1);
         check("t6_idx", m, 32'(di[m]), 32'd0);
      end

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         clr      = ($urandom_range(0, 60) == 0);
         a3       = rnd_val();
         t        = rnd_val();
         @(negedge clk);
      end
      in_valid = 1'b0; clr = 1'b0;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
